ram_port_arbiter: RTL and testbench

Shares the processor's single synchronous RAM port among up to NUM_REQ requesters: instruction fetch (0), data load/store (1), and a video/debug DMA reader (2). Each requester runs a req/gnt/rvalid handshake. The arbiter sequences one RAM access at a time onto bus_RAM_ADDRESS, wire_RW and bus_RAM_DATA_IN, and returns read data from bus_RAM_DATA_OUT to the owning requester. It sits between the CPU and DMA masters and the RAM macro.

---
 rtl/ram_arb_pkg.sv | 16 +
 rtl/ram_arb_picker.sv | 53 +++++
 rtl/ram_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter.
// Round-robin selection is enabled with RAM_ARB_ROUND_ROBIN_EN.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } arb_state_e;

  localparam int MAX_REQ   = 4;
  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_DMA   = 2;

endpackage

// File: rtl/ram_arb_picker.sv
// Combinational winner select: fixed priority, or round-robin
// from ptr+1 when RAM_ARB_ROUND_ROBIN_EN is defined.
module ram_arb_picker
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
`ifdef RAM_ARB_ROUND_ROBIN_EN
  ,
  parameter int PW = 2
`endif
) (
`ifdef RAM_ARB_ROUND_ROBIN_EN
  input  logic [PW-1:0]      ptr,
`endif
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] win,
  output logic               any
);

  assign any = |req;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  int best;
  int dist;

  // Smallest rotated distance from ptr+1 wins.
  always_comb begin
    win  = '0;
    best = NUM_REQ;
    dist = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dist = i - int'(ptr) - 1;
      if (dist < 0) dist = dist + NUM_REQ;
      if (req[i] && dist < best) begin
        best   = dist;
        win    = '0;
        win[i] = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win    = '0;
        win[i] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous RAM port among NUM_REQ requesters.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin selection.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic                         wire_clock,
  input  logic                         wire_reset_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ-1:0][AW-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DW-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           rvalid,
  output logic [DW-1:0]                rdata,
  output logic [AW-1:0]                bus_RAM_ADDRESS,
  output logic                         wire_RW,
  output logic [DW-1:0]                bus_RAM_DATA_IN,
  input  logic [DW-1:0]                bus_RAM_DATA_OUT,
  output logic                         busy
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam int PW = (NUM_REQ > 2) ? 2 : 1;
  logic [PW-1:0] ptr_q, ptr_d;
`endif

  arb_state_e state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [NUM_REQ-1:0] win_q, win_d;
  logic [NUM_REQ-1:0] pick;
  logic               any_req;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               rw_q, rw_d;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_wdata;
  logic               sel_we;

  ram_arb_picker #(
    .NUM_REQ (NUM_REQ)
`ifdef RAM_ARB_ROUND_ROBIN_EN
    ,
    .PW      (PW)
`endif
  ) u_picker (
`ifdef RAM_ARB_ROUND_ROBIN_EN
    .ptr (ptr_q),
`endif
    .req (req),
    .win (pick),
    .any (any_req)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        sel_addr  = sel_addr | req_addr[i];
        sel_wdata = sel_wdata | req_wdata[i];
        sel_we    = sel_we | req_we[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = '0;
    rvalid_d = '0;
    win_d    = win_q;
    rdata_d  = rdata_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    rw_d     = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    ptr_d    = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACCESS;
          win_d   = pick;
          gnt_d   = pick;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          rw_d    = sel_we;
        end
      end
      ACCESS: begin
        state_d = rw_q ? IDLE : CAPTURE;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        for (int i = 0; i < NUM_REQ; i++) begin
          if (win_q[i]) ptr_d = PW'(i);
        end
`endif
      end
      CAPTURE: begin
        rdata_d  = bus_RAM_DATA_OUT;
        rvalid_d = win_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wire_clock) begin
    if (!wire_reset_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rvalid_q <= '0;
      win_q    <= '0;
      rdata_q  <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      ptr_q    <= PW'(NUM_REQ - 1);
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      win_q    <= win_d;
      rdata_q  <= rdata_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign gnt             = gnt_q;
  assign rvalid          = rvalid_q;
  assign rdata           = rdata_q;
  assign bus_RAM_ADDRESS = addr_q;
  assign wire_RW         = rw_q;
  assign bus_RAM_DATA_IN = wdata_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: expected grants and
// read returns are queued by stimulus and popped by a monitor.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 16;

  logic                 clk;
  logic                 rst_n;
  logic [N-1:0]         req;
  logic [N-1:0]         req_we;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_wdata;
  logic [N-1:0]         gnt;
  logic [N-1:0]         rvalid;
  logic [DW-1:0]        rdata;
  logic [AW-1:0]        ram_addr;
  logic                 ram_rw;
  logic [DW-1:0]        ram_din;
  logic [DW-1:0]        ram_dout;
  logic                 busy;

  ram_port_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
    .wire_clock       (clk),
    .wire_reset_n     (rst_n),
    .req              (req),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .gnt              (gnt),
    .rvalid           (rvalid),
    .rdata            (rdata),
    .bus_RAM_ADDRESS  (ram_addr),
    .wire_RW          (ram_rw),
    .bus_RAM_DATA_IN  (ram_din),
    .bus_RAM_DATA_OUT (ram_dout),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [0:4095];
  always @(posedge clk) begin
    if (ram_rw) mem[ram_addr[11:0]] <= ram_din;
    ram_dout <= mem[ram_addr[11:0]];
  end

  typedef struct {
    int          idx;
    int          cyc;
    logic [15:0] addr;
    logic        we;
    logic [15:0] data;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];
  exp_t ge;
  exp_t re;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (gnt !== '0) begin
      if (gq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_gnt: got %b expected none (cycle %0d)",
                 gnt, cyc);
      end else begin
        ge = gq.pop_front();
        chk("gnt_vec", 32'(gnt), 32'(1) << ge.idx);
        chk("gnt_cycle", cyc, ge.cyc);
        chk("gnt_addr", 32'(ram_addr), 32'(ge.addr));
        chk("gnt_rw", 32'(ram_rw), 32'(ge.we));
        if (ge.we) chk("gnt_wdata", 32'(ram_din), 32'(ge.data));
      end
    end
    if (rvalid !== '0) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got %b expected none (cycle %0d)",
                 rvalid, cyc);
      end else begin
        re = rq.pop_front();
        chk("rvalid_vec", 32'(rvalid), 32'(1) << re.idx);
        chk("rvalid_cycle", cyc, re.cyc);
        chk("rdata", 32'(rdata), 32'(re.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_gnt(input int i, input int c, input logic [15:0] a,
                          input logic w, input logic [15:0] d);
    exp_t e;
    e.idx = i; e.cyc = c; e.addr = a; e.we = w; e.data = d;
    gq.push_back(e);
  endtask

  task automatic push_rv(input int i, input int c, input logic [15:0] d);
    exp_t e;
    e.idx = i; e.cyc = c; e.addr = '0; e.we = 1'b0; e.data = d;
    rq.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_rvalid"}, 32'(rvalid), 0);
    chk({tag, "_rdata"}, 32'(rdata), 0);
    chk({tag, "_addr"}, 32'(ram_addr), 0);
    chk({tag, "_rw"}, 32'(ram_rw), 0);
    chk({tag, "_din"}, 32'(ram_din), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic do_write(input int i, input logic [15:0] a,
                          input logic [15:0] d);
    push_gnt(i, cyc + 1, a, 1'b1, d);
    req_we[i] = 1'b1; req_addr[i] = a; req_wdata[i] = d; req[i] = 1'b1;
    tick();
    tick();
    req[i] = 1'b0;
    @(negedge clk);
    chk("wr_rw_after", 32'(ram_rw), 0);
    tick();
  endtask

  task automatic do_read(input int i, input logic [15:0] a,
                         input logic [15:0] d);
    push_gnt(i, cyc + 1, a, 1'b0, '0);
    push_rv(i, cyc + 3, d);
    req_we[i] = 1'b0; req_addr[i] = a; req[i] = 1'b1;
    tick();
    tick();
    req[i] = 1'b0;
    @(negedge clk);
    chk("rd_capture_rw", 32'(ram_rw), 0);
    chk("rd_capture_busy", 32'(busy), 1);
    tick();
    tick();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  int base;
  int rr;

  initial begin
    for (int k = 0; k < 4096; k++) mem[k] = '0;
    mem[12'h010] = 16'hA5A5;
    rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    rr = 1;
`else
    rr = 0;
`endif
    tick(); tick(); tick();
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(); tick();

    do_write(REQ_DATA, 16'h1234, 16'hBEEF);
    tick();
    do_read(REQ_FETCH, 16'h0010, 16'hA5A5);
    tick();

    // Reset asserted during the CAPTURE cycle of a DMA read.
    push_gnt(REQ_DMA, cyc + 1, 16'h0040, 1'b0, '0);
    req_we[REQ_DMA] = 1'b0; req_addr[REQ_DMA] = 16'h0040; req[REQ_DMA] = 1'b1;
    tick();
    tick();
    req[REQ_DMA] = 1'b0;
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("midreset_rvalid_late", 32'(rvalid), 0);
    tick();

    // Read from 0 with a write from 1 already pending.
    base = cyc;
    push_gnt(0, base + 1, 16'h0010, 1'b0, '0);
    push_rv(0, base + 3, 16'hA5A5);
    push_gnt(1, base + 4, 16'h0020, 1'b1, 16'h1111);
    req_we = 3'b010;
    req_addr[0] = 16'h0010;
    req_addr[1] = 16'h0020; req_wdata[1] = 16'h1111;
    req = 3'b011;
    tick();
    tick();
    req[0] = 1'b0;
    tick();
    tick();
    tick();
    req[1] = 1'b0;
    tick();
    pulse_reset();

    // All three requesters write continuously.
    base = cyc;
    req_we = 3'b111;
    for (int i = 0; i < N; i++) begin
      req_addr[i]  = 16'h0100 + 16'(i);
      req_wdata[i] = 16'hC000 + 16'(i);
    end
    for (int k = 0; k < 6; k++) begin
      int w;
      w = rr ? (k % 3) : 0;
      push_gnt(w, base + 1 + 2 * k, 16'h0100 + 16'(w), 1'b1,
               16'hC000 + 16'(w));
    end
    push_gnt(1, base + 13, 16'h0101, 1'b1, 16'hC001);
    push_gnt(2, base + 15, 16'h0102, 1'b1, 16'hC002);
    req = 3'b111;
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (t == 12) req[0] = 1'b0;
      if (t == 14) req[1] = 1'b0;
      if (t == 16) req[2] = 1'b0;
    end
    tick();

    do_read(REQ_DATA, 16'h1234, 16'hBEEF);
    do_read(REQ_DMA, 16'h0020, 16'h1111);
    do_read(REQ_FETCH, 16'h0102, 16'hC002);

    tick(); tick(); tick();
    chk("gnt_queue_drained", gq.size(), 0);
    chk("rvalid_queue_drained", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
